cc4_viterbi_decoder: RTL and testbench

Hard-decision Viterbi decoder for the 8-state, rate-1/2 convolutional code produced by the `Convolutional_Code_4` encoder. Per data bit u, the code emits the pair (sym1 = u⊕b2⊕b4, sym2 = u⊕b2⊕b3⊕b4), where b2..b4 are the three previous data bits. The block sits directly downstream of the encoder/noise stage and takes its `out1`/`out2` pair as `sym1`/`sym2`. It recovers the data stream using add-compare-select plus a register-exchange survivor memory, and emits bits after a fixed decoding depth.

---
 rtl/cc4_pkg.sv | 28 ++
 rtl/cc4_acs_unit.sv | 35 +++
 rtl/cc4_viterbi_decoder.sv | 152 +++++++++++++++
 tb/tb_cc4_viterbi_decoder.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cc4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cc4_pkg
//  Description : Shared definitions for the Convolutional_Code_4 Viterbi
//                decoder: state count, generator polynomials, state type and
//                the expected-symbol function used by the branch metrics.
//  Revision    : 1.0 - initial release
// ============================================================================
package cc4_pkg;

    localparam int NUM_STATES = 8;

    // Generator taps over {u, b2, b3, b4}, MSB = current data bit.
    localparam logic [3:0] G1 = 4'b1101;
    localparam logic [3:0] G2 = 4'b1111;

    // {b2, b3, b4}; bit 2 is the most recent data bit.
    typedef logic [2:0] state_t;

    // Returns {e1, e2}: the symbol pair emitted when input u leaves 'state'.
    function automatic logic [1:0] cc4_expected(input state_t state, input logic u);
        logic [3:0] w_taps;
        w_taps = {u, state};
        return {^(w_taps & G1), ^(w_taps & G2)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cc4_acs_unit.sv
`default_nettype none
// ============================================================================
//  Module      : cc4_acs_unit
//  Description : Add-compare-select for one next state. Adds each branch
//                metric to its predecessor metric and keeps the smaller sum.
//                Ties resolve to predecessor 0.
//  Ports       : i_pm0/i_pm1  predecessor path metrics (p0, p1)
//                i_bm0/i_bm1  branch metrics p0->n, p1->n (0..2)
//                o_pm         selected metric, one bit wider (no overflow)
//                o_sel        1 when p1 was selected
//  Revision    : 1.0 - initial release
// ============================================================================
module cc4_acs_unit #(
    parameter int PM_W = 6
) (
    input  logic [PM_W-1:0] i_pm0,
    input  logic [PM_W-1:0] i_pm1,
    input  logic [1:0]      i_bm0,
    input  logic [1:0]      i_bm1,
    output logic [PM_W:0]   o_pm,
    output logic            o_sel
);

    logic [PM_W:0] w_cand0;
    logic [PM_W:0] w_cand1;

    assign w_cand0 = {1'b0, i_pm0} + {{(PM_W-1){1'b0}}, i_bm0};
    assign w_cand1 = {1'b0, i_pm1} + {{(PM_W-1){1'b0}}, i_bm1};

    // Strict less-than so that equal candidates keep p0.
    assign o_sel = (w_cand1 < w_cand0);
    assign o_pm  = o_sel ? w_cand1 : w_cand0;

endmodule
`default_nettype wire

// File: rtl/cc4_viterbi_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : cc4_viterbi_decoder
//  Description : Hard-decision Viterbi decoder for the 8-state rate-1/2
//                Convolutional_Code_4 code. Eight ACS units feed a same-cycle
//                min/normalize stage; survivors use register exchange and the
//                decision is read TB_DEPTH accepted symbols deep.
//  Ports       : clock, reset (async, active-high)
//                in_valid, sym1, sym2   received symbol pair
//                out_valid, out_bit     decoded bit (registered)
//                metric_min             metric removed by normalization this
//                                       step (saturated); 0 on a clean channel
//  Revision    : 1.0 - initial release
// ============================================================================
module cc4_viterbi_decoder
    import cc4_pkg::*;
#(
    parameter int PM_W     = 6,
    parameter int TB_DEPTH = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    input  logic            sym1,
    input  logic            sym2,
    output logic            out_valid,
    output logic            out_bit,
    output logic [PM_W-1:0] metric_min
);

    localparam int                c_CNT_W   = $clog2(TB_DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(TB_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TB_DEPTH - 1);
    localparam logic [PM_W-1:0]   c_PM_MAX  = '1;
    // Large start metric for non-zero states pins decoding to the encoder's
    // all-zero start state.
    localparam logic [PM_W-1:0]   c_PM_INIT = {1'b1, {(PM_W-1){1'b0}}};

    logic [NUM_STATES-1:0][PM_W-1:0]     r_pm;
    logic [NUM_STATES-1:0][TB_DEPTH-1:0] r_surv;
    logic [c_CNT_W-1:0]                  r_cnt;
    logic                                r_out_valid;
    logic                                r_out_bit;
    logic [PM_W-1:0]                     r_metric_min;

    logic [NUM_STATES-1:0][PM_W:0]       w_pm_new;
    logic [NUM_STATES-1:0]               w_sel;
    logic [NUM_STATES-1:0][TB_DEPTH-1:0] w_surv_new;
    logic [NUM_STATES-1:0][PM_W-1:0]     w_pm_norm;
    logic [PM_W:0]                       w_min;
    logic [PM_W:0]                       w_diff;
    state_t                              w_best;
    logic                                w_out_bit;
    logic [PM_W-1:0]                     w_min_sat;

    // ------------------------------------------------------------------
    // Trellis: next state n = {u, n[1], n[0]} is reached from
    // p0 = {n[1], n[0], 0} and p1 = {n[1], n[0], 1} with input u = n[2].
    // ------------------------------------------------------------------
    for (genvar n = 0; n < NUM_STATES; n++) begin : g_acs
        localparam state_t c_P0 = state_t'((n % 4) * 2);
        localparam state_t c_P1 = state_t'((n % 4) * 2 + 1);
        localparam logic   c_U  = (n >= 4);

        logic [1:0] w_e0;
        logic [1:0] w_e1;
        logic [1:0] w_bm0;
        logic [1:0] w_bm1;

        assign w_e0  = cc4_expected(c_P0, c_U);
        assign w_e1  = cc4_expected(c_P1, c_U);
        assign w_bm0 = {1'b0, (sym1 != w_e0[1])} + {1'b0, (sym2 != w_e0[0])};
        assign w_bm1 = {1'b0, (sym1 != w_e1[1])} + {1'b0, (sym2 != w_e1[0])};

        cc4_acs_unit #(
            .PM_W (PM_W)
        ) u_acs (
            .i_pm0 (r_pm[c_P0]),
            .i_pm1 (r_pm[c_P1]),
            .i_bm0 (w_bm0),
            .i_bm1 (w_bm1),
            .o_pm  (w_pm_new[n]),
            .o_sel (w_sel[n])
        );

        // Register exchange: inherit the chosen predecessor's history and
        // append the input bit that this transition implies.
        assign w_surv_new[n] = w_sel[n] ? {r_surv[c_P1][TB_DEPTH-2:0], c_U}
                                        : {r_surv[c_P0][TB_DEPTH-2:0], c_U};
    end

    // 8-way minimum of the freshly selected metrics.
    always_comb begin
        w_min = w_pm_new[0];
        for (int i = 1; i < NUM_STATES; i++) begin
            if (w_pm_new[i] < w_min) begin
                w_min = w_pm_new[i];
            end
        end
    end

    // Normalize, saturate, and pick the lowest-index zero-metric state.
    // Scanning downward lets the lowest index overwrite higher ones.
    always_comb begin
        w_diff    = '0;
        w_pm_norm = '0;
        w_best    = '0;
        for (int i = NUM_STATES - 1; i >= 0; i--) begin
            w_diff       = w_pm_new[i] - w_min;
            w_pm_norm[i] = w_diff[PM_W] ? c_PM_MAX : w_diff[PM_W-1:0];
            if (w_diff == '0) begin
                w_best = state_t'(i);
            end
        end
    end

    assign w_out_bit = w_surv_new[w_best][TB_DEPTH-1];
    assign w_min_sat = w_min[PM_W] ? c_PM_MAX : w_min[PM_W-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                r_pm[i]   <= (i == 0) ? '0 : c_PM_INIT;
                r_surv[i] <= '0;
            end
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_out_bit    <= 1'b0;
            r_metric_min <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (in_valid) begin
                r_pm         <= w_pm_norm;
                r_surv       <= w_surv_new;
                r_out_bit    <= w_out_bit;
                r_metric_min <= w_min_sat;
                // Counting this accept, the survivor is full once the prior
                // count has reached TB_DEPTH-1.
                r_out_valid  <= (r_cnt >= c_CNT_LAST);
                if (r_cnt != c_CNT_FULL) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_bit    = r_out_bit;
    assign metric_min = r_metric_min;

endmodule
`default_nettype wire

// File: tb/tb_cc4_viterbi_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cc4_viterbi_decoder
//  Description : Directed self-checking bench for cc4_viterbi_decoder.
//                Symbols come from a bench-side encoder model or a literal
//                table; decoded bits are checked against the source data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cc4_viterbi_decoder;

    localparam int PM_W     = 6;
    localparam int TB_DEPTH = 16;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            sym1 = 1'b0;
    logic            sym2 = 1'b0;
    logic            out_valid;
    logic            out_bit;
    logic [PM_W-1:0] metric_min;

    int checks   = 0;
    int failures = 0;

    logic [2:0] enc_s;

    always #5 clock = ~clock;

    cc4_viterbi_decoder #(
        .PM_W     (PM_W),
        .TB_DEPTH (TB_DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .sym1       (sym1),
        .sym2       (sym2),
        .out_valid  (out_valid),
        .out_bit    (out_bit),
        .metric_min (metric_min)
    );

    // Drive one cycle; returns #1 after the edge so registered outputs
    // reflect the symbol just driven.
    task automatic step(input logic v, input logic s1, input logic s2);
        in_valid = v;
        sym1     = s1;
        sym2     = s2;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        sym1     = 1'b0;
        sym2     = 1'b0;
        reset    = 1'b1;
        @(posedge clock);
        #1;
        reset    = 1'b0;
    endtask

    // Reference encoder: s = {b2,b3,b4}, s1 = u^b2^b4, s2 = u^b2^b3^b4.
    task automatic encode(input logic u, output logic s1, output logic s2);
        s1    = u ^ enc_s[2] ^ enc_s[0];
        s2    = u ^ enc_s[2] ^ enc_s[1] ^ enc_s[0];
        enc_s = {u, enc_s[2], enc_s[1]};
    endtask

    // Encodes 64 data bits plus 16 zero flush bits, optionally flipping
    // sym1 at flip1 and sym2 at flip2 and idling every third cycle.
    task automatic run_stream(input logic [63:0] data, input int flip1, input int flip2,
                              input bit gaps, input string name);
        int   sym_idx = 0;
        int   cyc     = 0;
        int   dec_idx = 0;
        logic u, s1, s2, exp_bit, exp_v;
        enc_s = 3'b000;
        while (sym_idx < 80) begin
            if (gaps && (cyc % 3 == 2)) begin
                step(1'b0, 1'b0, 1'b0);
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_gap_valid cyc=%0d got=%b expected=0", name, cyc, out_valid);
                end
            end else begin
                u = (sym_idx < 64) ? data[sym_idx] : 1'b0;
                encode(u, s1, s2);
                if (sym_idx == flip1) s1 = ~s1;
                if (sym_idx == flip2) s2 = ~s2;
                step(1'b1, s1, s2);
                exp_v = (sym_idx >= TB_DEPTH - 1);
                checks++;
                if (out_valid !== exp_v) begin
                    failures++;
                    $display("FAIL %s_valid sym=%0d got=%b expected=%b", name, sym_idx, out_valid, exp_v);
                end
                if (out_valid === 1'b1) begin
                    exp_bit = (dec_idx < 64) ? data[dec_idx] : 1'b0;
                    checks++;
                    if (out_bit !== exp_bit) begin
                        failures++;
                        $display("FAIL %s_bit idx=%0d got=%b expected=%b", name, dec_idx, out_bit, exp_bit);
                    end
                    dec_idx++;
                end
                checks++;
                if (!(metric_min <= 6'd2)) begin
                    failures++;
                    $display("FAIL %s_metric sym=%0d got=%0d expected<=2", name, sym_idx, metric_min);
                end
                sym_idx++;
            end
            cyc++;
        end
        checks++;
        if (dec_idx != 80 - (TB_DEPTH - 1)) begin
            failures++;
            $display("FAIL %s_count got=%0d expected=%0d", name, dec_idx, 80 - (TB_DEPTH - 1));
        end
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_bit !== 1'b0 || metric_min !== 6'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b/%b/%0d expected=0/0/0", out_valid, out_bit, metric_min);
        end
        checks++;
        if (dut.r_pm[0] !== 6'd0) begin
            failures++;
            $display("FAIL reset_pm0 got=%0d expected=0", dut.r_pm[0]);
        end
        for (int i = 1; i < 8; i++) begin
            checks++;
            if (dut.r_pm[i] !== 6'd32) begin
                failures++;
                $display("FAIL reset_pm%0d got=%0d expected=32", i, dut.r_pm[i]);
            end
        end
        reset = 1'b0;
        // Idle cycles must not produce output.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle_valid cyc=%0d got=%b expected=0", i, out_valid);
            end
        end
    endtask

    task automatic test_all_zero();
        int first = -1;
        do_reset();
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (out_valid === 1'b1 && first < 0) first = i + 1;
            checks++;
            if (out_valid !== (i >= TB_DEPTH - 1)) begin
                failures++;
                $display("FAIL zero_valid acc=%0d got=%b expected=%b", i + 1, out_valid, (i >= TB_DEPTH - 1));
            end
            checks++;
            if (out_bit !== 1'b0 || metric_min !== 6'd0) begin
                failures++;
                $display("FAIL zero_bit_metric acc=%0d got=%b/%0d expected=0/0", i + 1, out_bit, metric_min);
            end
        end
        checks++;
        if (first != TB_DEPTH) begin
            failures++;
            $display("FAIL zero_first_valid got=%0d expected=%0d", first, TB_DEPTH);
        end
    endtask

    // Data 1 then zeros; the 1 is the first decoded bit, emitted after the
    // 16th accepted symbol.
    task automatic test_impulse();
        logic [1:0] tab [4];
        logic [1:0] pair;
        int         dec_idx = 0;
        tab = '{2'b11, 2'b11, 2'b01, 2'b11};
        do_reset();
        for (int i = 0; i < 48; i++) begin
            pair = (i < 4) ? tab[i] : 2'b00;
            step(1'b1, pair[1], pair[0]);
            checks++;
            if (out_valid !== (i >= TB_DEPTH - 1)) begin
                failures++;
                $display("FAIL impulse_valid acc=%0d got=%b expected=%b", i + 1, out_valid, (i >= TB_DEPTH - 1));
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (out_bit !== (dec_idx == 0)) begin
                    failures++;
                    $display("FAIL impulse_bit idx=%0d got=%b expected=%b", dec_idx, out_bit, (dec_idx == 0));
                end
                dec_idx++;
            end
            checks++;
            if (metric_min !== 6'd0) begin
                failures++;
                $display("FAIL impulse_metric acc=%0d got=%0d expected=0", i + 1, metric_min);
            end
        end
    endtask

    task automatic test_error_correction();
        do_reset();
        run_stream(64'hB5E2_9C47_0F3A_D168, 10, 30, 1'b0, "errcorr");
    endtask

    task automatic test_gaps();
        do_reset();
        run_stream(64'hB5E2_9C47_0F3A_D168, 10, 30, 1'b1, "gaps");
    endtask

    task automatic test_reset_midstream();
        logic [63:0] data_a;
        logic        s1, s2;
        data_a = 64'h3C96_E0A5_71DB_482F;
        do_reset();
        enc_s = 3'b000;
        for (int i = 0; i < 40; i++) begin
            encode(data_a[i], s1, s2);
            step(1'b1, s1, s2);
        end
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL midreset_pre_valid got=%b expected=1", out_valid);
        end
        // Assert reset between edges; outputs must clear without a clock.
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_bit !== 1'b0 || metric_min !== 6'd0) begin
            failures++;
            $display("FAIL midreset_async got=%b/%b/%0d expected=0/0/0", out_valid, out_bit, metric_min);
        end
        checks++;
        if (dut.r_pm[5] !== 6'd32) begin
            failures++;
            $display("FAIL midreset_pm5 got=%0d expected=32", dut.r_pm[5]);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        run_stream(64'h9A5F_0C3E_6D21_B784, -1, -1, 1'b0, "midreset");
    endtask

    task automatic test_saturation();
        int   zero_found;
        logic first_bad;
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            zero_found = 0;
            first_bad  = 1'b0;
            for (int s = 0; s < 8; s++) begin
                if ($isunknown(dut.r_pm[s])) first_bad = 1'b1;
                if (dut.r_pm[s] === 6'd0) zero_found = 1;
            end
            checks++;
            if (first_bad || $isunknown({out_valid, out_bit, metric_min})) begin
                failures++;
                $display("FAIL sat_unknown cyc=%0d got=%b/%b/%h expected=known", i, out_valid, out_bit, metric_min);
            end
            checks++;
            if (zero_found == 0) begin
                failures++;
                $display("FAIL sat_zero_metric cyc=%0d got=none expected=at_least_one", i);
            end
            checks++;
            if (!(metric_min <= 6'd2)) begin
                failures++;
                $display("FAIL sat_metric_min cyc=%0d got=%0d expected<=2", i, metric_min);
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_impulse();
        test_error_correction();
        test_gaps();
        test_reset_midstream();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
